// File: rtl/adc_osr_decimator.sv
// Oversampling decimator: sums 2^m SAR conversions and emits one
// full-scale-normalised result through a valid/ready handshake.
module adc_osr_decimator #(
  parameter int INPUT_BITS  = 12,
  parameter int OUTPUT_BITS = 16,
  parameter int ACC_BITS    = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INPUT_BITS-1:0]  data_in,
  input  logic                   data_valid_in,
  input  logic                   enable_in,
  input  logic [2:0]             osr_mode_in,
  input  logic                   clear_overrun_in,
  output logic [OUTPUT_BITS-1:0] result_out,
  input  logic                   result_ready_in,
  output logic                   result_valid_out,
  output logic                   overrun_out,
  output logic                   busy_out
);

  localparam int SH_BITS = ACC_BITS + 4;

  logic [ACC_BITS-1:0]    acc_q, acc_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [2:0]             mode_q, mode_d;
  logic                   valid_d_q;
  logic [OUTPUT_BITS-1:0] result_q, result_d;
  logic                   rvalid_q, rvalid_d;
  logic                   ovr_q, ovr_d;

  logic                   start;
  logic                   accept;
  logic                   last;
  logic [2:0]             mode_eff;
  logic [7:0]             win_len;
  logic [ACC_BITS-1:0]    sum;
  logic [SH_BITS-1:0]     scaled;
  logic                   complete;
  logic                   can_load;
  logic                   unused_hi;

  always_comb begin
    start    = (cnt_q == 8'd0);
    mode_eff = start ? osr_mode_in : mode_q;
    accept   = data_valid_in & ~valid_d_q & enable_in;
    win_len  = 8'd1 << mode_eff;
    last     = (cnt_q + 8'd1) == win_len;
    sum      = (start ? '0 : acc_q)
             + {{(ACC_BITS-INPUT_BITS){1'b0}}, data_in};
    // S<<4>>m gives S<<(4-m) for small m and truncating S>>(m-4) above
    scaled   = {sum, 4'b0000} >> mode_eff;
    complete = accept & last;
    can_load = ~rvalid_q | result_ready_in;
  end

  assign unused_hi = ^scaled[SH_BITS-1:OUTPUT_BITS];

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;
    rvalid_d = rvalid_q;
    ovr_d    = ovr_q;
    if (!enable_in) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      mode_d = mode_eff;
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 8'd1;
      end
    end
    if (rvalid_q && result_ready_in) rvalid_d = 1'b0;
    if (clear_overrun_in) ovr_d = 1'b0;
    if (complete) begin
      if (can_load) begin
        result_d = scaled[OUTPUT_BITS-1:0];
        rvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      valid_d_q <= 1'b0;
      result_q  <= '0;
      rvalid_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      valid_d_q <= data_valid_in;
      result_q  <= result_d;
      rvalid_q  <= rvalid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign result_out       = result_q;
  assign result_valid_out = rvalid_q;
  assign overrun_out      = ovr_q;
  assign busy_out         = (cnt_q != 8'd0);

endmodule

// File: tb/tb_adc_osr_decimator.sv
// Scoreboard bench for adc_osr_decimator: stimulus pushes expected
// results, a negedge monitor pops them on every handshake transfer.
module tb_adc_osr_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] data_in;
  logic        data_valid_in;
  logic        enable_in;
  logic [2:0]  osr_mode_in;
  logic        clear_overrun_in;
  logic [15:0] result_out;
  logic        result_valid_out;
  logic        result_ready_in;
  logic        overrun_out;
  logic        busy_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  adc_osr_decimator dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in          (data_in),
    .data_valid_in    (data_valid_in),
    .enable_in        (enable_in),
    .osr_mode_in      (osr_mode_in),
    .clear_overrun_in (clear_overrun_in),
    .result_out       (result_out),
    .result_ready_in  (result_ready_in),
    .result_valid_out (result_valid_out),
    .overrun_out      (overrun_out),
    .busy_out         (busy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next posedge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && result_valid_out && result_ready_in) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %0d expected none",
                 result_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (result_out !== e) begin
          n_fail++;
          $display("FAIL result: got %0d expected %0d", result_out, e);
        end
      end
    end
  end

  task automatic pulse_hi(input logic [11:0] d, input int hold);
    data_in       = d;
    data_valid_in = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    data_valid_in = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] d);
    pulse_hi(d, 1);
    gap();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n            = 1'b0;
    data_in          = '0;
    data_valid_in    = 1'b0;
    enable_in        = 1'b1;
    osr_mode_in      = 3'd0;
    clear_overrun_in = 1'b0;
    result_ready_in  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result_out, 0);
    check("rst_valid", result_valid_out, 0);
    check("rst_overrun", overrun_out, 0);
    check("rst_busy", busy_out, 0);
    rst_n = 1'b1;
    gap();

    // mode 0 latency
    exp_q.push_back(16'hABC0);
    pulse_hi(12'hABC, 1);
    check("m0_valid", result_valid_out, 1);
    check("m0_data", result_out, 16'hABC0);
    gap();
    check("m0_valid_drop", result_valid_out, 0);

    // mode 2
    osr_mode_in = 3'd2;
    exp_q.push_back(16'd1624);
    strobe(12'd100);
    check("m2_busy1", busy_out, 1);
    strobe(12'd101);
    strobe(12'd102);
    check("m2_busy3", busy_out, 1);
    strobe(12'd103);
    check("m2_busy_end", busy_out, 0);

    // full scale modes 7 and 4, mode 5
    osr_mode_in = 3'd7;
    exp_q.push_back(16'd65520);
    for (int i = 0; i < 128; i++) strobe(12'd4095);
    osr_mode_in = 3'd4;
    exp_q.push_back(16'd65520);
    for (int i = 0; i < 16; i++) strobe(12'd4095);
    osr_mode_in = 3'd5;
    exp_q.push_back(16'd16);
    for (int i = 0; i < 32; i++) strobe(12'd1);
    exp_q.push_back(16'd1);
    for (int i = 0; i < 32; i++) strobe(i == 0 ? 12'd3 : 12'd0);

    // overrun
    result_ready_in = 1'b0;
    osr_mode_in     = 3'd0;
    exp_q.push_back(16'h0050);
    strobe(12'd5);
    strobe(12'd9);
    check("ovr_hold", result_out, 16'h0050);
    check("ovr_valid", result_valid_out, 1);
    check("ovr_flag", overrun_out, 1);
    result_ready_in = 1'b1;
    gap();
    check("ovr_xfer", result_valid_out, 0);
    result_ready_in = 1'b0;
    exp_q.push_back(16'h0070);
    strobe(12'd7);
    clear_overrun_in = 1'b1;
    pulse_hi(12'd3, 1);
    clear_overrun_in = 1'b0;
    check("ovr_set_wins", overrun_out, 1);
    check("ovr_keep", result_out, 16'h0070);
    gap();
    clear_overrun_in = 1'b1;
    gap();
    clear_overrun_in = 1'b0;
    check("ovr_clear", overrun_out, 0);
    result_ready_in = 1'b1;
    gap();
    check("ovr_xfer2", result_valid_out, 0);

    // held strobe and mode change mid-window
    osr_mode_in = 3'd1;
    exp_q.push_back(16'd240);
    pulse_hi(12'd10, 3);
    gap();
    check("hold_busy", busy_out, 1);
    osr_mode_in = 3'd3;
    strobe(12'd20);
    check("msw_busy_end", busy_out, 0);
    exp_q.push_back(16'd72);
    for (int i = 1; i <= 8; i++) begin
      strobe(12'(i));
      if (i == 7) check("m3_busy7", busy_out, 1);
    end
    check("m3_busy_end", busy_out, 0);

    // reset mid-window
    osr_mode_in = 3'd2;
    strobe(12'd500);
    strobe(12'd500);
    check("pre_rst_busy", busy_out, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy_out, 0);
    gap();
    rst_n = 1'b1;
    gap();
    exp_q.push_back(16'd40);
    for (int i = 1; i <= 4; i++) strobe(12'(i));

    // disable mid-window
    strobe(12'd700);
    strobe(12'd700);
    enable_in = 1'b0;
    gap();
    check("dis_busy", busy_out, 0);
    enable_in = 1'b1;
    exp_q.push_back(16'd104);
    for (int i = 5; i <= 8; i++) strobe(12'(i));

    repeat (5) gap();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
